oam_dma_ctrl: RTL and testbench

Memory-bus controller and arbiter between the CPU datapath (fetcher/decoder/data bus) and the single-port `mem` block, implementing NES-style sprite DMA. A CPU write to `TRIGGER_ADDR` is intercepted and latched as a source page. The controller then stalls the CPU through `cpu_rdy` and takes ownership of the memory port. It copies 256 bytes from `{page, 8'h00}`..`{page, 8'hFF}` to `OAM_DATA_ADDR`, then returns the bus to the CPU.

---
 rtl/oam_dma_ctrl.sv | 135 +++++++++++++
 tb/tb_oam_dma_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl
// Memory-bus controller and arbiter between the CPU datapath and the single
// port mem block, implementing NES-style sprite DMA. A CPU write to
// TRIGGER_ADDR is swallowed and its data latched as a source page. The CPU
// is then stalled while 256 bytes {page,8'h00}..{page,8'hFF} are copied to
// OAM_DATA_ADDR, one READ/WRITE pair per byte, reads always on even parity.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   cpu_addr/we/wdata CPU access request (ignored while busy)
//   cpu_rdy           bus grant to the CPU
//   mem_addr/we/wdata request to mem; mem_rdata returns one cycle later
//   dma_busy          high in every non-IDLE state
//   dma_done          one-cycle pulse in the first IDLE cycle after a copy
//   dbg_state_o       current FSM state
//   last_byte_o       last byte moved by the DMA
//
// Handshake: cpu_rdy is a level grant. While cpu_rdy=1 each CPU request is
// forwarded to mem in the same cycle; while cpu_rdy=0 the CPU must hold off,
// and anything it drives is ignored (no forwarding, no re-trigger).
module oam_dma_ctrl #(
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    REG_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [REG_WIDTH-1:0]  cpu_wdata,
  output logic                  cpu_rdy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic                  dma_busy,
  output logic                  dma_done,
  output logic [2:0]            dbg_state_o,
  output logic [REG_WIDTH-1:0]  last_byte_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  parity_q;
  logic [7:0]            page_q;
  logic [7:0]            idx_q;
  logic [REG_WIDTH-1:0]  last_q;
  logic                  rdy_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  trigger;
  logic [ADDR_WIDTH-1:0] src_addr;

  assign trigger  = (state_q == S_IDLE) && cpu_we && (cpu_addr == TRIGGER_ADDR);
  // Only idx advances, so page FF never carries into page 00.
  assign src_addr = ADDR_WIDTH'({page_q, idx_q});

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (trigger) state_d = S_HALT;
      // parity_q is this cycle's parity; a READ needs next cycle to be even.
      S_HALT:  state_d = parity_q ? S_READ : S_ALIGN;
      S_ALIGN: state_d = S_READ;
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = (idx_q == 8'hFF) ? S_IDLE : S_READ;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory port mux. While reset is held the port shows the idle
  // pass-through view with writes suppressed.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_we    = 1'b0;
    mem_wdata = cpu_wdata;
    if (!reset) begin
      unique case (state_q)
        S_IDLE:  mem_we = cpu_we && !trigger;
        S_WRITE: begin
          mem_addr  = OAM_DATA_ADDR;
          mem_we    = 1'b1;
          mem_wdata = mem_rdata;
        end
        default: begin
          mem_addr  = src_addr;
          mem_wdata = mem_rdata;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      parity_q <= 1'b0;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      last_q   <= '0;
      rdy_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      rdy_q    <= (state_d == S_IDLE);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_q == S_WRITE) && (idx_q == 8'hFF);
      if (trigger) begin
        page_q <= cpu_wdata[7:0];
        idx_q  <= 8'h00;
      end
      if (state_q == S_WRITE) begin
        last_q <= mem_rdata;
        if (idx_q != 8'hFF) idx_q <= idx_q + 8'h01;
      end
    end
  end

  assign cpu_rdy     = rdy_q;
  assign dma_busy    = busy_q;
  assign dma_done    = done_q;
  assign dbg_state_o = state_q;
  assign last_byte_o = last_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: directed trigger scenarios, registered-ROM memory
// model, and a negedge monitor that pops expected DMA writes from exp_q.
module tb_oam_dma_ctrl;

  localparam logic [15:0] OAM = 16'h2004;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        dma_busy;
  logic        dma_done;
  logic [2:0]  dbg_state;
  logic [7:0]  last_byte;

  oam_dma_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_we      (cpu_we),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdy     (cpu_rdy),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .dma_busy    (dma_busy),
    .dma_done    (dma_done),
    .dbg_state_o (dbg_state),
    .last_byte_o (last_byte)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle parity as seen by the bench (0 after reset, toggles each clock).
  logic par_m;
  always @(posedge clk) par_m <= reset ? 1'b0 : ~par_m;

  // Source pattern held in memory.
  function automatic logic [7:0] rom(input logic [15:0] a);
    case (a[15:8])
      8'h02:   rom = a[7:0] ^ 8'hA5;
      8'h03:   rom = a[7:0] ^ 8'h3C;
      8'hFF:   rom = ~a[7:0];
      default: rom = 8'hEE;
    endcase
  endfunction

  // Registered memory, one cycle read latency.
  always @(posedge clk) mem_rdata <= rom(mem_addr);

  // ---------------- scoreboard ----------------
  logic [24:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int stall_cnt, done_cnt, dma_wr_cnt, any_we_cnt, zero_acc;
  bit wrap_chk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [24:0] e;
    forever begin
      @(negedge clk);
      if (!cpu_rdy) stall_cnt++;
      if (dma_done) done_cnt++;
      if (mem_we) any_we_cnt++;
      if (wrap_chk && dma_busy && mem_addr[15:8] == 8'h00) zero_acc++;
      if (dma_busy && mem_we) begin
        dma_wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_dma_write", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("dma_write{par,addr,data}", 32'({par_m, mem_addr, mem_wdata}), 32'(e));
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_addr  = 16'h0000;
    cpu_we    = 1'b0;
    cpu_wdata = 8'h00;
  endtask

  // Queue the 256 expected writes (WRITE always on odd parity) and issue the
  // trigger write. Called at posedge+1.
  task automatic issue_trigger(input logic [7:0] pg);
    for (int i = 0; i < 256; i++)
      exp_q.push_back({1'b1, OAM, rom({pg, 8'(i)})});
    stall_cnt  = 0;
    done_cnt   = 0;
    dma_wr_cnt = 0;
    cpu_addr   = 16'h4014;
    cpu_we     = 1'b1;
    cpu_wdata  = pg;
    @(negedge clk);
    check("trigger_not_forwarded", 32'(mem_we), 32'd0);
    tick();
    cpu_idle();
  endtask

  task automatic run_dma(input logic [7:0] pg, input logic want_par, input bit iso,
                         input int exp_stall, input logic [7:0] exp_last);
    bit got_done;
    for (int g = 0; g < 2 && par_m !== want_par; g++) tick();
    issue_trigger(pg);
    got_done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (dma_done) begin
        got_done = 1'b1;
        break;
      end
      if (iso && i < 500) begin
        cpu_addr  = (i % 2 == 0) ? 16'h4014 : 16'h0050;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_wdata = 8'($urandom_range(0, 255));
      end else begin
        cpu_idle();
      end
    end
    check("dma_done_seen", 32'(got_done), 32'd1);
    tick();
    check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("writes_left", 32'(exp_q.size()), 32'd0);
    check("last_byte", 32'(last_byte), 32'(exp_last));
    check("rdy_after_dma", 32'(cpu_rdy), 32'd1);
    repeat (4) tick();
    check("no_retrigger", 32'(dma_busy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit hit;
    reset = 1'b1;
    cpu_idle();
    stall_cnt = 0; done_cnt = 0; dma_wr_cnt = 0; any_we_cnt = 0; zero_acc = 0;
    wrap_chk = 1'b0;
    fork
      monitor();
    join_none
    repeat (2) tick();
    reset = 1'b0;

    // Reset state and pass-through
    @(negedge clk);
    check("reset_rdy", 32'(cpu_rdy), 32'd1);
    check("reset_busy", 32'(dma_busy), 32'd0);
    check("reset_we", 32'(mem_we), 32'd0);
    check("reset_done", 32'(dma_done), 32'd0);
    check("reset_last", 32'(last_byte), 32'd0);
    tick();
    cpu_addr = 16'h1234;
    @(negedge clk);
    check("pt_read_addr", 32'(mem_addr), 32'h1234);
    check("pt_read_we", 32'(mem_we), 32'd0);
    tick();
    cpu_addr = 16'h0010; cpu_we = 1'b1; cpu_wdata = 8'h5A;
    @(negedge clk);
    check("pt_write", 32'({mem_addr, mem_we, mem_wdata}), 32'({16'h0010, 1'b1, 8'h5A}));
    tick();
    cpu_addr = 16'h4015; cpu_we = 1'b1; cpu_wdata = 8'h11;
    @(negedge clk);
    check("pt_4015", 32'({mem_addr, mem_we, mem_wdata}), 32'({16'h4015, 1'b1, 8'h11}));
    tick();
    cpu_idle();
    @(negedge clk);
    check("no_trigger_4015", 32'(dma_busy), 32'd0);

    // Reset held in the trigger cycle discards the trigger
    tick();
    reset = 1'b1;
    cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_wdata = 8'h77;
    tick();
    reset = 1'b0;
    cpu_idle();
    @(negedge clk);
    check("rst_trig_busy", 32'(dma_busy), 32'd0);
    tick();
    @(negedge clk);
    check("rst_trig_busy2", 32'(dma_busy), 32'd0);
    tick();

    // Even-parity DMA with CPU toggling while busy
    run_dma(8'h02, 1'b0, 1'b1, 513, 8'h5A);
    // Odd-parity DMA
    run_dma(8'h02, 1'b1, 1'b0, 514, 8'h5A);
    // Page wrap
    zero_acc = 0;
    wrap_chk = 1'b1;
    run_dma(8'hFF, 1'b0, 1'b0, 513, 8'h00);
    wrap_chk = 1'b0;
    check("page_wrap_no_page00", 32'(zero_acc), 32'd0);

    // Reset after the 100th DMA write
    issue_trigger(8'h02);
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (dma_wr_cnt >= 100) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    check("reached_100_writes", 32'(dma_wr_cnt), 32'd100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    dma_wr_cnt = 0; any_we_cnt = 0; done_cnt = 0;
    @(negedge clk);
    check("midrst_rdy", 32'(cpu_rdy), 32'd1);
    check("midrst_busy", 32'(dma_busy), 32'd0);
    repeat (20) tick();
    check("midrst_no_writes", 32'(any_we_cnt), 32'd0);
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    if (!hit) check("midrst_timeout", 32'd1, 32'd0);
    run_dma(8'h03, 1'b0, 1'b0, 513, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
